// File: rtl/junction_sequencer_pkg.sv
// Shared turn-command codes and sequencer state encoding, also imported by the drive controller.
package junction_sequencer_pkg;

    typedef enum logic [2:0] {
        TD_HOLD    = 3'd0,
        TD_FORWARD = 3'd1,
        TD_LEFT    = 3'd2,
        TD_RIGHT   = 3'd3,
        TD_REVERSE = 3'd4,
        TD_STOP    = 3'd5
    } td_e;

    typedef enum logic [2:0] {
        ST_ARM       = 3'd0,
        ST_DECIDE_RT = 3'd1,
        ST_DECIDE_LV = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_COMPLETE  = 3'd4
    } state_e;

    // Codes 6 and 7 carry no meaning downstream and collapse to HOLD.
    function automatic logic [2:0] td_sanitize(input logic [2:0] code);
        return (code > TD_STOP) ? TD_HOLD : code;
    endfunction

    function automatic logic td_is_decision(input logic [2:0] code);
        return (code != TD_HOLD) && (code <= TD_STOP);
    endfunction

endpackage

// File: rtl/junction_sequencer_route_queue.sv
// Programmed-route store: append-only entry array with read index, count and done flag.
// Define JUNCTION_SEQ_LOOP_EN to wrap the read index back to 0 after the last entry.
module junction_sequencer_route_queue
    import junction_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [2:0]        i_wr_data,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [2:0]        o_entry,
    output logic [ADDR_W-1:0] o_idx,
    output logic [ADDR_W:0]   o_count,
    output logic              o_done
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    logic [2:0]      r_mem [DEPTH];
    logic [ADDR_W:0] r_count;
    logic [ADDR_W:0] r_idx;
    logic            r_done;
    logic [ADDR_W:0] w_count_nxt;
    logic [ADDR_W:0] w_idx_nxt;
    logic            w_push;

    assign w_push = i_wr_en && !i_clear && (r_count != FULL);

    always_comb begin
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        if (i_clear) begin
            w_count_nxt = '0;
            w_idx_nxt   = '0;
        end else begin
            if (w_push)
                w_count_nxt = r_count + ONE;
            // The guard keeps the index from passing the count if the route shrank mid-decision.
            if (i_advance && (r_idx < r_count)) begin
`ifdef JUNCTION_SEQ_LOOP_EN
                w_idx_nxt = (r_idx + ONE == r_count) ? '0 : r_idx + ONE;
`else
                w_idx_nxt = r_idx + ONE;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_idx   <= '0;
            r_done  <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= (w_idx_nxt == w_count_nxt);
        end
    end

    // NOTE: the entry array has no reset; entries beyond the count are never read.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_count[ADDR_W-1:0]] <= i_wr_data;
    end

    assign o_entry = r_mem[r_idx[ADDR_W-1:0]];
    assign o_idx   = r_idx[ADDR_W-1:0];
    assign o_count = r_count;
    assign o_done  = r_done;

endmodule

// File: rtl/junction_sequencer.sv
// Junction decision sequencer: serves turn commands from the programmed route or debounced live tones.
// Route looping is selected in the route queue by JUNCTION_SEQ_LOOP_EN.
module junction_sequencer
    import junction_sequencer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_tone_detection,
    input  logic [2:0]        tone_live,
    input  logic              route_mode,
    input  logic              route_wr_en,
    input  logic [2:0]        route_wr_data,
    input  logic              route_clear,
    output logic [2:0]        tone_dir,
    output logic [ADDR_W-1:0] route_idx,
    output logic [ADDR_W:0]   route_count,
    output logic              route_done,
    output logic              timeout_flag
);

    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e           r_state, w_state_nxt;
    logic [2:0]       r_tone, w_tone_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_en_q;
    logic [2:0]       r_prev, w_prev_nxt;
    logic [DB_W-1:0]  r_db, w_db_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic             r_from_rt, w_from_rt_nxt;
    logic             w_advance;
    logic             w_match;
    logic [2:0]       w_entry;

    junction_sequencer_route_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_route_queue (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (route_wr_en),
        .i_wr_data (route_wr_data),
        .i_clear   (route_clear),
        .i_advance (w_advance),
        .o_entry   (w_entry),
        .o_idx     (route_idx),
        .o_count   (route_count),
        .o_done    (route_done)
    );

    assign w_match = (tone_live == r_prev) && td_is_decision(tone_live);

    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_tone_nxt    = r_tone;
        w_timeout_nxt = 1'b0;
        w_prev_nxt    = TD_HOLD;
        w_db_nxt      = '0;
        w_tmr_nxt     = '0;
        w_from_rt_nxt = r_from_rt;
        w_advance     = 1'b0;
        unique case (r_state)
            ST_ARM: begin
                w_tone_nxt = TD_HOLD;
                if (enable_tone_detection && !r_en_q) begin
                    w_from_rt_nxt = route_mode && !route_done;
                    w_state_nxt   = (route_mode && !route_done) ? ST_DECIDE_RT : ST_DECIDE_LV;
                end
            end
            ST_DECIDE_RT: begin
                if (!enable_tone_detection) begin
                    w_tone_nxt    = TD_HOLD;
                    w_from_rt_nxt = 1'b0;
                    w_state_nxt   = ST_ARM;
                end else begin
                    w_tone_nxt  = td_sanitize(w_entry);
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DECIDE_LV: begin
                if (!enable_tone_detection) begin
                    w_tone_nxt  = TD_HOLD;
                    w_state_nxt = ST_ARM;
                end else if ((r_db == DB_LAST) && w_match) begin
                    w_tone_nxt  = tone_live;
                    w_state_nxt = ST_ISSUE;
                end else if (r_tmr == TMR_LAST) begin
                    w_tone_nxt    = TD_STOP;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_ISSUE;
                end else begin
                    w_prev_nxt = tone_live;
                    w_db_nxt   = w_match ? r_db + 1'b1 : '0;
                    w_tmr_nxt  = r_tmr + 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!enable_tone_detection)
                    w_state_nxt = ST_COMPLETE;
            end
            ST_COMPLETE: begin
                w_tone_nxt    = TD_HOLD;
                w_advance     = r_from_rt;
                w_from_rt_nxt = 1'b0;
                w_state_nxt   = ST_ARM;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_ARM;
            r_tone    <= TD_HOLD;
            r_timeout <= 1'b0;
            r_en_q    <= 1'b0;
            r_prev    <= TD_HOLD;
            r_db      <= '0;
            r_tmr     <= '0;
            r_from_rt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tone    <= w_tone_nxt;
            r_timeout <= w_timeout_nxt;
            r_en_q    <= enable_tone_detection;
            r_prev    <= w_prev_nxt;
            r_db      <= w_db_nxt;
            r_tmr     <= w_tmr_nxt;
            r_from_rt <= w_from_rt_nxt;
        end
    end

    assign tone_dir     = r_tone;
    assign timeout_flag = r_timeout;

endmodule
